// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA memory bus arbiter: FSM encoding,
// master IDs and the read pattern returned on an aborted transaction.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam logic [31:0] ABORT_PATTERN = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
// A lone requester always wins; on a tie the master not granted last wins.
module rr_arbiter2
  import mem_bus_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_id,
  output logic o_valid
);

  always_comb begin
    o_valid    = i_req0 | i_req1;
    o_grant_id = M_CPU;
    if (i_req0 && i_req1) begin
      o_grant_id = ~i_last_grant;
    end else if (i_req1) begin
      o_grant_id = M_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: serialises CPU (master 0) and DMA (master 1) onto one memory bus.
// Defining MEM_ARB_TIMEOUT_EN adds a WAIT-state timeout that aborts the transaction.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no transaction; pick a requester and latch its command
//   ST_ISSUE | one-cycle mem_req start pulse to the controller
//   ST_WAIT  | waiting for mem_ack (or timeout when enabled)
//   ST_RESP  | one-cycle ack to the granted master; rdata/err valid
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk50M,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_is_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_is_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_is_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_abort
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_grant;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_is_write;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_arb_valid;
  logic              w_arb_id;
  logic              w_grant;
  logic              w_mem_done;
  logic              w_timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  rr_arbiter2 u_rr (
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .i_last_grant (r_last_grant),
    .o_grant_id   (w_arb_id),
    .o_valid      (w_arb_valid)
  );

  assign w_grant    = (r_state == ST_IDLE) && w_arb_valid;
  // mem_ack outside WAIT is a stray pulse and must not complete anything
  assign w_mem_done = (r_state == ST_WAIT) && mem_ack;

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req     = 1'b0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req     = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_mem_done || w_timeout) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        m0_ack      = (r_grant == M_CPU);
        m1_ack      = (r_grant == M_DMA);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // last_grant resets to DMA so the CPU wins the first tie
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst) begin
      r_grant        <= M_DMA;
      r_last_grant   <= M_DMA;
      r_mem_addr     <= '0;
      r_mem_is_write <= 1'b0;
      r_mem_wdata    <= '0;
      r_rdata        <= '0;
    end else begin
      if (w_grant) begin
        r_grant        <= w_arb_id;
        r_mem_addr     <= (w_arb_id == M_DMA) ? m1_addr     : m0_addr;
        r_mem_is_write <= (w_arb_id == M_DMA) ? m1_is_write : m0_is_write;
        r_mem_wdata    <= (w_arb_id == M_DMA) ? m1_wdata    : m0_wdata;
      end
      if (w_mem_done) begin
        r_rdata <= mem_rdata;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (w_timeout) begin
        r_rdata <= DATA_W'(ABORT_PATTERN);
      end
`endif
      if (r_state == ST_RESP) begin
        r_last_grant <= r_grant;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic              r_err;

  // held at zero outside WAIT, so it is already clear on entry
  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)                   r_tcnt <= '0;
    else if (r_state != ST_WAIT) r_tcnt <= '0;
    else if (!mem_ack)          r_tcnt <= r_tcnt + TCNT_W'(1);
  end

  // a mem_ack in the final WAIT cycle beats the timeout
  assign w_timeout = (r_state == ST_WAIT) && !mem_ack && (r_tcnt == TCNT_LAST);

  always_ff @(posedge clk50M or negedge rst) begin
    if (!rst)            r_err <= 1'b0;
    else if (w_mem_done) r_err <= 1'b0;
    else if (w_timeout)  r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign mem_abort    = w_timeout;
  assign mem_addr     = r_mem_addr;
  assign mem_is_write = r_mem_is_write;
  assign mem_wdata    = r_mem_wdata;
  assign rdata        = r_rdata;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter that shares the single physical memory/peripheral bus (RAM, flash, serial, VGA, keyboard, SL811 windows) between the CPU (master 0) and a DMA-class requester (master 1).
Sits between the requesters and the physical memory controller. Serialises one transaction at a time with round-robin fairness. Returns read data and completion to the winning master.

Parameters:
ADDR_W, 32, address width of master and bus address ports
DATA_W, 32, data width of write/read data
TIMEOUT_CYCLES, 1023, WAIT-state cycles before abort (used only with MEM_ARB_TIMEOUT_EN; must be >=1)

Ports:
clk50M  input  1  system clock; all state on rising edge
rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately
m0_req  input  1  CPU request; held high with stable addr/is_write/wdata until m0_ack
m0_addr  input  ADDR_W  CPU address
m0_is_write  input  1  CPU transaction is a write
m0_wdata  input  DATA_W  CPU write data
m0_ack  output  1  one-cycle completion pulse to CPU
m1_req  input  1  DMA request; same holding rule as m0_req
m1_addr  input  ADDR_W  DMA address
m1_is_write  input  1  DMA transaction is a write
m1_wdata  input  DATA_W  DMA write data
m1_ack  output  1  one-cycle completion pulse to DMA
rdata  output  DATA_W  read data; valid in the cycle m0_ack or m1_ack is high; shared by both masters
err  output  1  transaction aborted by timeout; qualified by m0_ack/m1_ack
mem_req  output  1  one-cycle start pulse to memory controller
mem_addr  output  ADDR_W  latched address of granted transaction
mem_is_write  output  1  latched direction
mem_wdata  output  DATA_W  latched write data
mem_rdata  input  DATA_W  controller read data; valid with mem_ack
mem_ack  input  1  controller completion pulse
mem_abort  output  1  one-cycle pulse: controller must drop the current transaction

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=1, so m0 wins the first tie; timeout counter 0. Reset in any state aborts silently; no ack is issued.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the master != last_grant. On grant, register addr/is_write/wdata into mem_* and go to ISSUE. If no req, stay in IDLE.
- ISSUE: mem_req=1 for exactly one cycle; go to WAIT. mem_* outputs stay stable from ISSUE through RESP.
- WAIT: on mem_ack, latch mem_rdata into rdata (writes latch it too; the value is don't-care for writes), set err=0, go to RESP. mem_ack in any state other than WAIT is ignored.
- RESP: mX_ack=1 for the granted master only; rdata/err held; last_grant updated to this master; go to IDLE.
- Minimum latency: req sampled in cycle t; mem_req in t+1; mem_ack earliest t+2; mX_ack in t+3.
- Back-to-back: a master holding req after its ack is resampled in IDLE the following cycle. With both masters requesting continuously, grants alternate strictly.
- A req that drops before grant is simply not granted. A req that drops after grant has no effect; the transaction completes normally.
- rdata and err hold their value until the next RESP.

Optional Feature:
MEM_ARB_TIMEOUT_EN: when defined, a counter clears on entry to WAIT and increments each WAIT cycle without mem_ack.
- On reaching TIMEOUT_CYCLES: mem_abort pulses for one cycle; go to RESP with err=1 and rdata=32'hDEADBEEF.
- mem_ack arriving in the same cycle as the timeout wins: normal completion, no abort.
When undefined: WAIT blocks indefinitely; mem_abort and err are tied to 0; no counter logic is built.

Decomposition:
- Shared package/header (mem_arb_def.vh): state encodings (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3), master IDs (M_CPU=0, M_DMA=1), abort read pattern 32'hDEADBEEF.
- One natural sub-module: rr_arbiter2, the combinational round-robin pick from (req0, req1, last_grant) to grant_id/valid.

Test Plan:
- Single CPU read: m0_req with addr=0x00000100; mem_ack one cycle after mem_req with mem_rdata=0x12345678 -> m0_ack in cycle t+3, rdata=0x12345678, err=0, m1_ack stays 0.
- Simultaneous requests out of reset: m0 and m1 both request, each held through its ack -> CPU granted first, then DMA; mem_addr follows m0_addr then m1_addr; each ack pulses exactly once.
- Continuous contention over 8 transactions -> grants alternate 0,1,0,1,...; no master receives two consecutive grants.
- DMA write: m1_is_write=1, wdata=0xCAFEF00D -> mem_wdata=0xCAFEF00D and mem_is_write=1 from ISSUE through RESP; m1_ack pulses once.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): mem_ack withheld -> mem_abort pulses after 4 WAIT cycles; then m0_ack with err=1 and rdata=0xDEADBEEF. Variant with mem_ack on the 4th cycle -> normal completion, no abort.
- rst driven low during WAIT -> all outputs 0 immediately, no ack; after release, a pending m1_req is granted normally.
